load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Multi-cycle initiator that drives the word-addressed data memory on behalf of the datapath's MEM stage. It accepts one RISC-V load or store request at a time, aligns byte and half accesses, and sign- or zero-extends load results. Sub-word stores use read-modify-write. Misaligned, illegal and out-of-range accesses are rejected before any memory access is issued.

Parameters:
MEM_WORDS, 35, number of 32-bit words in the data memory; legal byte addresses are 0 to MEM_WORDS*4-1.

Ports:
Clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request; high only in IDLE
req_store  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data; the byte or half is taken from the low bits
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
resp_err  output  1  request rejected; qualified by resp_valid
mem_addr  output  32  word-aligned byte address (bits [1:0] = 0)
mem_wdata  output  32  full word to write
mem_read  output  1  read enable
mem_write  output  1  write enable; memory writes on the posedge ending this cycle
mem_rdata  input  32  combinational memory read data; valid in the same cycle as mem_read

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE and all captured request fields clear.
- Reset values: req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts the request. No mem_write is issued after the reset edge, and no resp_valid is produced for the aborted request.
- States: IDLE, READ, WRITE, RESP.
- IDLE: a request is accepted on an edge where req_valid && req_ready. The unit captures addr, wdata, funct3 and store.
- Transitions out of IDLE on acceptance:
  - error -> RESP
  - load -> READ
  - sub-word store (SB, SH) -> READ
  - SW -> WRITE
- Error conditions (any one sets resp_err):
  - funct3 not in {000, 001, 010, 100, 101}
  - a store with funct3 100 or 101
  - H/HU with addr[0]=1
  - W with addr[1:0]!=0
  - addr >= MEM_WORDS*4
- READ: mem_read=1 and mem_addr = addr with bits [1:0] cleared. mem_rdata is sampled on the ending edge. A load then goes to RESP; a sub-word store goes to WRITE.
- WRITE: mem_write=1 for exactly one cycle, and mem_addr is the aligned address. Then go to RESP.
  - SW: mem_wdata = wdata.
  - SB: the sampled word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: the sampled word with half lane addr[1] replaced by wdata[15:0].
- RESP: resp_valid=1 for one cycle, then return to IDLE.
- Load extraction:
  - The byte lane is selected by addr[1:0]; the half lane by addr[1].
  - B and H sign-extend from bit 7 and bit 15 respectively. BU and HU zero-extend.
  - W passes the word through unchanged.
- Latency from the acceptance edge T:
  - error: resp at T+1
  - load: resp at T+2
  - SW: resp at T+2
  - SB/SH: resp at T+3
- mem_read and mem_write are never high together. Both are 0 in IDLE and RESP, and mem_addr and mem_wdata hold their last values.
- req_ready=0 in READ, WRITE and RESP. req_valid is ignored in those states and no request is queued, so back-to-back throughput is one request per latency plus 1 cycle.
- resp_rdata and resp_err are combinational from registered state and are stable throughout RESP.

Test Plan:
1. SW addr 0x4, wdata 0x876543F1 -> T+1: mem_write=1, mem_addr=0x4, mem_wdata=0x876543F1, mem_read=0. T+2: resp_valid=1, resp_err=0.
2. Loads on that word, each checked at T+2 with resp_err=0:
   - LB 0x4 -> 0xFFFFFFF1
   - LBU 0x4 -> 0x000000F1
   - LH 0x6 -> 0xFFFF8765
   - LHU 0x6 -> 0x00008765
   - LW 0x4 -> 0x876543F1
3. SB addr 0x5, wdata 0x123456AA -> T+1: mem_read=1, mem_addr=0x4. T+2: mem_write=1, mem_wdata=0x8765AAF1. T+3: resp_valid=1. A following LW 0x4 returns 0x8765AAF1.
4. Rejected requests -> resp_valid=1, resp_err=1 at T+1, resp_rdata=0, and mem_read/mem_write stay 0 throughout:
   - LW 0x6 (misaligned)
   - SH 0x3 (misaligned)
   - LW 0x8C with MEM_WORDS=35 (out of range)
   - load with funct3 011 (illegal)
5. SH addr 0x8 with reset asserted on the edge ending READ -> next cycle: all outputs at reset values, no mem_write ever pulses, resp_valid never pulses. A subsequent LW 0x8 returns the original contents.
6. req_valid held high with a second request queued behind an LW -> req_ready=0 for T+1 and T+2. The second request is accepted only on the edge ending the IDLE cycle at T+3, and exactly two resp_valid pulses occur.

Source files
------------

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//
// Bundles the request/response handshake between the MEM stage and the
// load/store unit together with the word-addressed data memory bus.
//
// Handshake: a request transfers on a rising clock edge where
// req_valid && req_ready. resp_valid is a one-cycle pulse that carries
// resp_rdata and resp_err. No backpressure exists on the response side.
//
// Signals:
//   req_valid/req_ready    request handshake
//   req_store              1 = store, 0 = load
//   req_funct3             RISC-V funct3 (B, H, W, BU, HU)
//   req_addr/req_wdata     byte address and store data
//   resp_valid/resp_rdata/resp_err   completion pulse, load data, reject flag
//   mem_addr/mem_wdata/mem_read/mem_write   memory command (word aligned)
//   mem_rdata              combinational memory read data
//
// Modports:
//   slave  - the load/store unit
//   master - the datapath plus memory (the surrounding environment)
// ---------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle initiator for the data memory on behalf of the MEM stage.
// Accepts one RISC-V load/store at a time, aligns byte/half accesses,
// sign/zero-extends loads, and performs read-modify-write for SB/SH.
// Misaligned, illegal and out-of-range requests are answered with resp_err
// without touching memory.
//
// Ports:
//   Clk          clock, all state updates on posedge
//   reset        synchronous, active-high
//   bus          load_store_unit_if.slave (request, response, memory bus)
//   o_dbg_state  current FSM state (IDLE=0, READ=1, WRITE=2, RESP=3)
//
// Latency from acceptance edge T: error T+1, load T+2, SW T+2, SB/SH T+3.
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_WORDS = 35
) (
    input  logic                 Clk,
    input  logic                 reset,
    load_store_unit_if.slave     bus,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_lane;       // addr[1:0] of the captured request
    logic [15:0] r_wdata;      // only the byte/half lanes are needed after capture
    logic [2:0]  r_funct3;
    logic        r_store;
    logic        r_err;
    logic [31:0] r_rdata;      // word sampled in READ
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_accept;
    logic        w_err;
    logic        w_is_sw;
    logic [31:0] w_merge;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_is_sw  = bus.req_store && (bus.req_funct3 == 3'b010);

    // Request legality, evaluated on the live request in IDLE.
    always_comb begin
        w_err = 1'b0;
        case (bus.req_funct3)
            3'b000:  w_err = 1'b0;
            3'b001:  w_err = bus.req_addr[0];
            3'b010:  w_err = |bus.req_addr[1:0];
            3'b100:  w_err = bus.req_store;
            3'b101:  w_err = bus.req_store | bus.req_addr[0];
            default: w_err = 1'b1;
        endcase
        if (bus.req_addr >= ADDR_LIMIT) begin
            w_err = 1'b1;
        end
    end

    // Sub-word store merge into the word currently on mem_rdata.
    // funct3[0] distinguishes SH (1) from SB (0).
    always_comb begin
        w_merge = bus.mem_rdata;
        if (r_funct3[0]) begin
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        end else begin
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    // Load lane extraction and extension.
    always_comb begin
        w_byte = r_rdata[{r_lane, 3'b000} +: 8];
        w_half = r_rdata[{r_lane[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = r_rdata;
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = 32'h0;
        endcase
    end

    // State register and captured request fields.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_lane      <= 2'b00;
            r_wdata     <= 16'h0;
            r_funct3    <= 3'b000;
            r_store     <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_lane   <= bus.req_addr[1:0];
                r_wdata  <= bus.req_wdata[15:0];
                r_funct3 <= bus.req_funct3;
                r_store  <= bus.req_store;
                r_err    <= w_err;
                // Memory command registers only move for legal requests so
                // mem_addr/mem_wdata hold their last values through errors.
                if (!w_err) begin
                    r_mem_addr <= {bus.req_addr[31:2], 2'b00};
                    if (w_is_sw) begin
                        r_mem_wdata <= bus.req_wdata;
                    end
                end
            end
            if (r_state == READ) begin
                r_rdata <= bus.mem_rdata;
                if (r_store) begin
                    r_mem_wdata <= w_merge;
                end
            end
        end
    end

    // Next state and handshake/command outputs.
    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_err) begin
                        w_next = RESP;
                    end else if (w_is_sw) begin
                        w_next = WRITE;
                    end else begin
                        w_next = READ;
                    end
                end
            end
            READ: begin
                bus.mem_read = 1'b1;
                w_next = r_store ? WRITE : RESP;
            end
            WRITE: begin
                bus.mem_write = 1'b1;
                w_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.resp_err   = (r_state == RESP) && r_err;
    assign bus.resp_rdata = ((r_state == RESP) && !r_store && !r_err) ? w_load : 32'h0;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit with a behavioural word memory.
// Inputs change #1 after a rising edge; outputs are sampled at that point,
// i.e. the "T+k" cycle is observed k edges after the acceptance edge T.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
    localparam int MEM_WORDS = 35;

    logic Clk;
    logic reset;
    logic [1:0] dbg_state;
    logic mem_init;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // -------------------------------------------------------------- clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ------------------------------------------------------------- memory
    logic [31:0] mem_model [0:MEM_WORDS-1];
    logic [29:0] mem_idx;

    assign mem_idx = bus.mem_addr[31:2];
    assign bus.mem_rdata = (mem_idx < MEM_WORDS) ? mem_model[mem_idx[5:0]] : 32'h0;

    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_model[i] <= (i == 2) ? 32'hCAFEF00D : 32'h0;
            end
        end else if (bus.mem_write && (mem_idx < MEM_WORDS)) begin
            mem_model[mem_idx[5:0]] <= bus.mem_wdata;
        end
    end

    // ----------------------------------------------------- pulse counters
    int n_wr;
    int n_rv;
    initial begin
        n_wr = 0;
        n_rv = 0;
    end
    always @(posedge Clk) begin
        if (bus.mem_write)  n_wr++;
        if (bus.resp_valid) n_rv++;
    end

    // ----------------------------------------------------------- checking
    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ drivers
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Presents a request while IDLE; returns one cycle after acceptance (T+1).
    task automatic send(input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    // Waits (bounded) for resp_valid; lat counts cycles from acceptance.
    task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
        lat = 1;
        while (!bus.resp_valid && lat < 8) begin
            tick();
            lat++;
        end
        rd = bus.resp_rdata;
        er = bus.resp_err;
        if (bus.resp_valid) tick();
    endtask

    task automatic load_check(input string tag, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] exp);
        int lat;
        logic [31:0] rd;
        logic er;
        send(1'b0, f3, addr, 32'h0);
        wait_resp(lat, rd, er);
        check({tag, " lat"},   32'(lat), 32'd2);
        check({tag, " err"},   {31'h0, er}, 32'h0);
        check({tag, " rdata"}, rd, exp);
    endtask

    task automatic err_check(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr);
        send(st, f3, addr, 32'hFFFF_FFFF);
        check({tag, " rvalid"}, {31'h0, bus.resp_valid}, 32'h1);
        check({tag, " err"},    {31'h0, bus.resp_err},   32'h1);
        check({tag, " rdata"},  bus.resp_rdata,          32'h0);
        check({tag, " memrw"},  {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        tick();
        check({tag, " idle"},   {31'h0, bus.req_ready},  32'h1);
    endtask

    task automatic reset_vals(input string tag);
        check({tag, " ready"},  {31'h0, bus.req_ready},  32'h1);
        check({tag, " rvalid"}, {31'h0, bus.resp_valid}, 32'h0);
        check({tag, " err"},    {31'h0, bus.resp_err},   32'h0);
        check({tag, " rdata"},  bus.resp_rdata,          32'h0);
        check({tag, " memrw"},  {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        check({tag, " maddr"},  bus.mem_addr,            32'h0);
        check({tag, " mwdata"}, bus.mem_wdata,           32'h0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int base_wr;
        int base_rv;
        n_tests = 0;
        n_fail  = 0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        reset    = 1'b1;
        mem_init = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        reset_vals("reset");
        reset    = 1'b0;
        mem_init = 1'b0;
        tick();

        // SW 0x4
        send(1'b1, 3'b010, 32'h4, 32'h876543F1);
        check("sw write",  {31'h0, bus.mem_write}, 32'h1);
        check("sw read",   {31'h0, bus.mem_read},  32'h0);
        check("sw maddr",  bus.mem_addr,           32'h4);
        check("sw mwdata", bus.mem_wdata,          32'h876543F1);
        tick();
        check("sw rvalid", {31'h0, bus.resp_valid}, 32'h1);
        check("sw err",    {31'h0, bus.resp_err},   32'h0);
        check("sw memrw",  {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        tick();

        // Loads on that word
        load_check("lb",  3'b000, 32'h4, 32'hFFFFFFF1);
        load_check("lbu", 3'b100, 32'h4, 32'h000000F1);
        load_check("lh",  3'b001, 32'h6, 32'hFFFF8765);
        load_check("lhu", 3'b101, 32'h6, 32'h00008765);
        load_check("lw",  3'b010, 32'h4, 32'h876543F1);
        load_check("lb3", 3'b000, 32'h7, 32'hFFFFFF87);
        load_check("lbu2", 3'b100, 32'h6, 32'h00000065);

        // SB 0x5 read-modify-write
        send(1'b1, 3'b000, 32'h5, 32'h123456AA);
        check("sb read",   {31'h0, bus.mem_read},  32'h1);
        check("sb write0", {31'h0, bus.mem_write}, 32'h0);
        check("sb maddr",  bus.mem_addr,           32'h4);
        tick();
        check("sb write",  {31'h0, bus.mem_write}, 32'h1);
        check("sb read1",  {31'h0, bus.mem_read},  32'h0);
        check("sb mwdata", bus.mem_wdata,          32'h8765AAF1);
        tick();
        check("sb rvalid", {31'h0, bus.resp_valid}, 32'h1);
        check("sb rdata",  bus.resp_rdata,          32'h0);
        tick();
        load_check("lw sb", 3'b010, 32'h4, 32'h8765AAF1);

        // Rejected requests
        err_check("e lw6",  1'b0, 3'b010, 32'h6);
        err_check("e sh3",  1'b1, 3'b001, 32'h3);
        err_check("e lw8c", 1'b0, 3'b010, 32'h8C);
        err_check("e f011", 1'b0, 3'b011, 32'h0);
        err_check("e sbu",  1'b1, 3'b100, 32'h0);
        load_check("lw 88", 3'b010, 32'h88, 32'h0);

        // Reset on the edge ending READ of an SH
        send(1'b1, 3'b001, 32'h8, 32'h1111BEEF);
        check("rst read", {31'h0, bus.mem_read}, 32'h1);
        base_wr = n_wr;
        base_rv = n_rv;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        reset_vals("rst mid");
        repeat (4) tick();
        check("rst no wr", 32'(n_wr - base_wr), 32'd0);
        check("rst no rv", 32'(n_rv - base_rv), 32'd0);
        load_check("lw 8", 3'b010, 32'h8, 32'hCAFEF00D);

        // Request held behind an LW
        base_rv = n_rv;
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h4;
        tick();
        bus.req_addr   = 32'h8;
        check("bp ready1", {31'h0, bus.req_ready}, 32'h0);
        check("bp maddr1", bus.mem_addr,           32'h4);
        tick();
        check("bp ready2", {31'h0, bus.req_ready},  32'h0);
        check("bp rv1",    {31'h0, bus.resp_valid}, 32'h1);
        check("bp rd1",    bus.resp_rdata,          32'h8765AAF1);
        tick();
        check("bp ready3", {31'h0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = 1'b0;
        check("bp read2",  {31'h0, bus.mem_read}, 32'h1);
        check("bp maddr2", bus.mem_addr,          32'h8);
        tick();
        check("bp rv2",    {31'h0, bus.resp_valid}, 32'h1);
        check("bp rd2",    bus.resp_rdata,          32'hCAFEF00D);
        repeat (3) tick();
        check("bp pulses", 32'(n_rv - base_rv), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
